fifo_uart_tx_drain: RTL

//  Read-side consumer of the async FIFO in the TX clock domain: pops one word at a time

---
 rtl/fifo_uart_tx_drain.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx_drain.sv
// Drains an async FIFO read port into a UART frame, one serial bit per CLK.
// Back-to-back frames when the next word is ready in the last stop cycle.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | line idle high; pops the FIFO head as soon as it is non-empty
// S_START  | start bit (0) on the line
// S_DATA   | data bits LSB first, bit_cnt = 0..DATA_WIDTH-1
// S_PARITY | parity bit of the latched word (only when parity latched on)
// S_STOP   | stop bits; last one may pop the next word and chain to S_START
module fifo_uart_tx_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FIFO_EMPTY,
    input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  FIFO_RD_INC,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state, state_next;
    logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
    logic [CNT_W-1:0]        bit_cnt, cnt_next;
    logic                    tx_q, tx_next;
    logic                    busy_q, busy_next;
    logic                    par_en_q, par_bit_q;
    logic                    pop_ok, load;

    // A pop is never issued while reset is asserted, so a reset cycle cannot eat a word.
    assign pop_ok = ~FIFO_EMPTY & ~RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state     <= state_next;
            tx_q      <= tx_next;
            busy_q    <= busy_next;
            bit_cnt   <= cnt_next;
            shift_reg <= shift_next;
            if (load) begin
                par_en_q  <= PAR_EN;
                par_bit_q <= PAR_TYP ^ (^FIFO_RD_DATA);
            end
        end
    end

    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        cnt_next   = bit_cnt;
        tx_next    = 1'b1;
        load       = 1'b0;
        case (state)
            S_IDLE: begin
                if (pop_ok) begin
                    load       = 1'b1;
                    state_next = S_START;
                    tx_next    = 1'b0;
                end
            end
            S_START: begin
                state_next = S_DATA;
                cnt_next   = '0;
                tx_next    = shift_reg[0];
                shift_next = shift_reg >> 1;
            end
            S_DATA: begin
                if (bit_cnt == LAST_DATA) begin
                    cnt_next = '0;
                    if (par_en_q) begin
                        state_next = S_PARITY;
                        tx_next    = par_bit_q;
                    end else begin
                        state_next = S_STOP;
                    end
                end else begin
                    cnt_next   = bit_cnt + 1'b1;
                    tx_next    = shift_reg[0];
                    shift_next = shift_reg >> 1;
                end
            end
            S_PARITY: begin
                state_next = S_STOP;
                cnt_next   = '0;
            end
            S_STOP: begin
                if (bit_cnt == LAST_STOP) begin
                    cnt_next = '0;
                    if (pop_ok) begin
                        load       = 1'b1;
                        state_next = S_START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    cnt_next = bit_cnt + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (load) shift_next = FIFO_RD_DATA;
        busy_next = (state_next != S_IDLE);
    end

    assign FIFO_RD_INC = load;
    assign TX_OUT      = tx_q;
    assign BUSY        = busy_q;

endmodule
